// File: rtl/jdec_ras.sv
// jdec_ras: jump decoder with circular return-address stack; define JDEC_RAS_STATS_EN for call/ret/ovf/unf counters
module jdec_ras #(
  parameter int DEPTH = 8,
  parameter int PC_W = 32,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d,
  input  logic            stall_d,
  input  logic            clear,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic [4:0]      rs,
  input  logic [4:0]      rd,
  input  logic [PC_W-1:0] pc_d,
  output logic            jsave,
  output logic            save_in_rd,
  output logic            jump_to_rs_val,
  output logic            is_call,
  output logic            is_return,
  output logic            pred_valid,
  output logic [PC_W-1:0] pred_target,
  output logic            ras_empty,
  output logic            ras_full
`ifdef JDEC_RAS_STATS_EN
  ,
  output logic [31:0]     call_cnt,
  output logic [31:0]     ret_cnt,
  output logic [31:0]     ovf_cnt,
  output logic [31:0]     unf_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [4:0] LINK = 5'(LINK_REG);
  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0] tos, tos_inc;
  logic [AW:0] cnt;
  logic r_type, jal, jr, jalr, upd;
  logic [PC_W-1:0] link;
  always_comb begin
    r_type = valid_d & (op == 6'h00);
    jal = valid_d & (op == OP_JAL);
    jr = r_type & (funct == FN_JR);
    jalr = r_type & (funct == FN_JALR);
    jsave = jal | jalr;
    save_in_rd = jalr;
    jump_to_rs_val = jr | jalr;
    is_call = jal | (jalr & (rd == LINK));
    is_return = (jr | jalr) & (rs == LINK);
    ras_empty = cnt == '0;
    ras_full = cnt == CNT_MAX;
    pred_valid = is_return & ~ras_empty;
    pred_target = pred_valid ? mem[tos] : '0;
    upd = valid_d & ~stall_d & ~clear & ~rst;
    tos_inc = tos + 1'b1;
    link = pc_d + PC_W'(8);
  end
  always_ff @(posedge clk) begin
    if (rst | clear) begin
      tos <= '0;
      cnt <= '0;
    end else if (upd) begin
      if (is_call & (~is_return | ras_empty)) begin
        tos <= tos_inc;
        mem[tos_inc] <= link;
        cnt <= ras_full ? cnt : cnt + 1'b1;
      end else if (is_call) begin
        mem[tos] <= link;
      end else if (is_return & ~ras_empty) begin
        tos <= tos - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
`ifdef JDEC_RAS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      call_cnt <= '0;
      ret_cnt <= '0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (upd) begin
      call_cnt <= call_cnt + {31'b0, is_call & ~&call_cnt};
      ret_cnt <= ret_cnt + {31'b0, is_return & ~&ret_cnt};
      ovf_cnt <= ovf_cnt + {31'b0, is_call & ~is_return & ras_full & ~&ovf_cnt};
      unf_cnt <= unf_cnt + {31'b0, is_return & ~is_call & ras_empty & ~&unf_cnt};
    end
  end
`endif
endmodule

// File: tb/tb_jdec_ras.sv
// tb_jdec_ras: directed plus randomized check of jdec_ras against a queue-based stack model
module tb_jdec_ras;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst, valid_d, stall_d, clear;
  logic [5:0] op, funct;
  logic [4:0] rs, rd;
  logic [31:0] pc_d, pred_target;
  logic jsave, save_in_rd, jump_to_rs_val, is_call, is_return, pred_valid, ras_empty, ras_full;
`ifdef JDEC_RAS_STATS_EN
  logic [31:0] call_cnt, ret_cnt, ovf_cnt, unf_cnt;
`endif
  int checks = 0, errors = 0;
  logic [31:0] stk[$];
  logic m_call, m_ret;
  jdec_ras #(.DEPTH(DEPTH), .PC_W(32), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .stall_d(stall_d), .clear(clear),
    .op(op), .funct(funct), .rs(rs), .rd(rd), .pc_d(pc_d),
    .jsave(jsave), .save_in_rd(save_in_rd), .jump_to_rs_val(jump_to_rs_val),
    .is_call(is_call), .is_return(is_return), .pred_valid(pred_valid),
    .pred_target(pred_target), .ras_empty(ras_empty), .ras_full(ras_full)
`ifdef JDEC_RAS_STATS_EN
    , .call_cnt(call_cnt), .ret_cnt(ret_cnt), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit v, input bit st, input bit cl, input bit r,
                       input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] d, input logic [31:0] pc);
    bit jal, jr, jalr, pv;
    valid_d = v; stall_d = st; clear = cl; rst = r;
    op = o; funct = f; rs = s; rd = d; pc_d = pc;
    #2;
    jal = v && o == 6'h03;
    jr = v && o == 6'h00 && f == 6'h08;
    jalr = v && o == 6'h00 && f == 6'h09;
    m_call = jal || (jalr && d == 5'd31);
    m_ret = (jr || jalr) && s == 5'd31;
    pv = m_ret && stk.size() > 0;
    check("jsave", {31'b0, jsave}, {31'b0, jal || jalr});
    check("save_in_rd", {31'b0, save_in_rd}, {31'b0, jalr});
    check("jump_to_rs", {31'b0, jump_to_rs_val}, {31'b0, jr || jalr});
    check("is_call", {31'b0, is_call}, {31'b0, m_call});
    check("is_return", {31'b0, is_return}, {31'b0, m_ret});
    check("pred_valid", {31'b0, pred_valid}, {31'b0, pv});
    check("pred_target", pred_target, pv ? stk[$] : 32'h0);
    check("ras_empty", {31'b0, ras_empty}, {31'b0, stk.size() == 0});
    check("ras_full", {31'b0, ras_full}, {31'b0, stk.size() == DEPTH});
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst || clear) stk.delete();
    else if (valid_d && !stall_d) begin
      if (m_call && (!m_ret || stk.size() == 0)) begin
        stk.push_back(pc_d + 32'd8);
        if (stk.size() > DEPTH) void'(stk.pop_front());
      end else if (m_call) stk[stk.size() - 1] = pc_d + 32'd8;
      else if (m_ret && stk.size() > 0) void'(stk.pop_back());
    end
    #1;
  endtask
  task automatic call(input logic [31:0] pc);
    drive(1, 0, 0, 0, 6'h03, 6'h00, 5'd0, 5'd0, pc);
    tick();
  endtask
  task automatic ret(input bit ev, input logic [31:0] et);
    drive(1, 0, 0, 0, 6'h00, 6'h08, 5'd31, 5'd0, 32'h0);
    check("ret_valid", {31'b0, pred_valid}, {31'b0, ev});
    check("ret_target", pred_target, et);
    tick();
  endtask
  initial begin
    drive(0, 0, 0, 1, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_full", {31'b0, ras_full}, 32'd0);
    check("rst_target", pred_target, 32'h0);
    drive(1, 1, 0, 0, 6'h03, 6'h00, 5'd0, 5'd0, 32'h0);
    check("jal_call", {31'b0, is_call}, 32'd1);
    drive(1, 1, 0, 0, 6'h00, 6'h08, 5'd31, 5'd0, 32'h0);
    check("jr31_ret", {31'b0, is_return}, 32'd1);
    drive(1, 1, 0, 0, 6'h00, 6'h09, 5'd4, 5'd31, 32'h0);
    drive(1, 1, 0, 0, 6'h00, 6'h09, 5'd4, 5'd5, 32'h0);
    check("jalr5_call", {31'b0, is_call}, 32'd0);
    drive(1, 1, 0, 0, 6'h00, 6'h08, 5'd4, 5'd0, 32'h0);
    check("jr4_ret", {31'b0, is_return}, 32'd0);
    check("jr4_pv", {31'b0, pred_valid}, 32'd0);
    drive(1, 1, 0, 0, 6'h00, 6'h20, 5'd31, 5'd31, 32'h0);
    check("add_jsave", {31'b0, jsave}, 32'd0);
    drive(0, 0, 0, 0, 6'h03, 6'h00, 5'd0, 5'd0, 32'h0);
    check("novalid_call", {31'b0, is_call}, 32'd0);
    tick();
    call(32'hBFC00100);
    ret(1, 32'hBFC00108);
    drive(0, 0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0);
    check("after_ret_empty", {31'b0, ras_empty}, 32'd1);
    call(32'h100); call(32'h200); call(32'h300);
    ret(1, 32'h308); ret(1, 32'h208); ret(1, 32'h108); ret(0, 32'h0);
    for (int k = 0; k < 9; k++) begin
      call(32'h1000 + 32'(16 * k));
      if (k == 7) check("full_after_8", {31'b0, ras_full}, 32'd1);
    end
    for (int k = 8; k >= 1; k--) ret(1, 32'h1000 + 32'(16 * k) + 32'd8);
    ret(0, 32'h0);
    call(32'h500); call(32'h600);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 6'h00, 6'h08, 5'd31, 5'd0, 32'h0);
      check("stall_target", pred_target, 32'h608);
      tick();
    end
    ret(1, 32'h608);
    drive(1, 0, 1, 0, 6'h03, 6'h00, 5'd0, 5'd0, 32'h700);
    tick();
    drive(0, 0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0);
    check("clear_empty", {31'b0, ras_empty}, 32'd1);
    call(32'h100); call(32'h200); ret(1, 32'h208);
    drive(1, 0, 0, 0, 6'h00, 6'h09, 5'd31, 5'd31, 32'h400);
    check("jalr_pp_target", pred_target, 32'h108);
    tick();
    drive(1, 1, 0, 0, 6'h00, 6'h08, 5'd31, 5'd0, 32'h0);
    check("pp_top", pred_target, 32'h408);
    drive(1, 0, 0, 1, 6'h03, 6'h00, 5'd0, 5'd0, 32'h900);
    tick();
    drive(0, 0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0);
    check("mid_rst_empty", {31'b0, ras_empty}, 32'd1);
    for (int i = 0; i < 600; i++) begin
      logic [5:0] o, f;
      logic [4:0] s, d;
      int sel = $urandom_range(0, 9);
      o = sel < 4 ? 6'h03 : sel < 9 ? 6'h00 : 6'($urandom);
      sel = $urandom_range(0, 4);
      f = sel < 2 ? 6'h08 : sel < 4 ? 6'h09 : 6'($urandom);
      s = $urandom_range(0, 2) != 0 ? 5'd31 : 5'($urandom);
      d = $urandom_range(0, 2) != 0 ? 5'd31 : 5'($urandom);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) == 0, o, f, s, d, {$urandom, 2'b00} == 34'h0 ? 32'h0 : $urandom & 32'hFFFF_FFFC);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
